// File: rtl/pool_window_sequencer.sv
// Pooling window sequencer: follows a raster-order, channel-interleaved pixel stream and
// strobes Cal_Valid when a KxK window completes. Optional watchdog: define POOL_WATCHDOG_EN.

module pool_window_sequencer #(
   parameter int IMG_W   = 24,
   parameter int IMG_H   = 24,
   parameter int CH      = 1,
   parameter int POOL_K  = 2,
   parameter int STRIDE  = 2,
   parameter int TIMEOUT = 1024,
   localparam int OUT_W  = (IMG_W - POOL_K) / STRIDE + 1,
   localparam int OUT_H  = (IMG_H - POOL_K) / STRIDE + 1,
   localparam int ROW_W  = (OUT_H > 1) ? $clog2(OUT_H) : 1,
   localparam int COL_W  = (OUT_W > 1) ? $clog2(OUT_W) : 1,
   localparam int CH_W   = (CH > 1) ? $clog2(CH) : 1
) (
   input  logic             S_AXIS_ACLK,
   input  logic             S_AXIS_ARESETN,
   input  logic             Din_Valid,
   output logic             Cal_Valid,
   output logic             Win_First,
   output logic [ROW_W-1:0] Out_Row,
   output logic [COL_W-1:0] Out_Col,
   output logic [CH_W-1:0]  Out_Ch,
   output logic             Frame_Done,
   output logic             Busy,
   output logic             Err
);

   localparam int XC_W = (IMG_W > 1) ? $clog2(IMG_W) : 1;
   localparam int YC_W = (IMG_H > 1) ? $clog2(IMG_H) : 1;
   localparam int PH_W = (POOL_K > 1) ? $clog2(POOL_K) : 1;

   localparam logic [CH_W-1:0] CH_LAST = CH_W'(CH - 1);
   localparam logic [XC_W-1:0] X_LAST  = XC_W'(IMG_W - 1);
   localparam logic [YC_W-1:0] Y_LAST  = YC_W'(IMG_H - 1);
   localparam logic [PH_W-1:0] PH_K1   = PH_W'(POOL_K - 1);
   localparam logic [PH_W-1:0] PH_S1   = PH_W'(STRIDE - 1);

   generate
      if (IMG_W < POOL_K || IMG_H < POOL_K || CH < 1 || POOL_K < 1 ||
          STRIDE < 1 || STRIDE > POOL_K || TIMEOUT < 1) begin : g_bad_cfg
         $error("pool_window_sequencer: illegal parameter combination");
      end
   endgenerate

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DONE
   } state_t;

   state_t state_q, state_d;

   logic [CH_W-1:0]  ch_cnt;
   logic [XC_W-1:0]  col_cnt;
   logic [YC_W-1:0]  row_cnt;
   logic [PH_W-1:0]  col_end_ph, row_end_ph;
   logic [PH_W-1:0]  col_st_ph, row_st_ph;
   logic [COL_W-1:0] out_col_cnt;
   logic [ROW_W-1:0] out_row_cnt;

   logic beat, ch_wrap, col_wrap, row_wrap;
   logic col_adv, row_adv, last_beat;
   logic col_hit, row_hit, win_hit;
   logic col_start, row_start;
   logic wd_fire;

   // end_ph counts down to the next window's last column/row; past the final window it
   // never reaches zero again before the wrap, so remainder columns/rows never complete
   assign beat      = Din_Valid;
   assign ch_wrap   = (ch_cnt == CH_LAST);
   assign col_wrap  = (col_cnt == X_LAST);
   assign row_wrap  = (row_cnt == Y_LAST);
   assign col_adv   = beat && ch_wrap;
   assign row_adv   = col_adv && col_wrap;
   assign last_beat = row_adv && row_wrap;

   assign col_hit   = (col_end_ph == '0);
   assign row_hit   = (row_end_ph == '0);
   assign win_hit   = beat && col_hit && row_hit;

   assign col_start = (col_st_ph == '0) && (int'(col_cnt) <= IMG_W - POOL_K);
   assign row_start = (row_st_ph == '0) && (int'(row_cnt) <= IMG_H - POOL_K);
   assign Win_First = beat && col_start && row_start;

   assign Busy      = (state_q == RUN);

`ifdef POOL_WATCHDOG_EN
   localparam int GAP_W = $clog2(TIMEOUT + 1);
   logic [GAP_W-1:0] gap_cnt;

   // Idle cycles while a frame is open; any beat or leaving RUN restarts the count
   assign wd_fire = (state_q == RUN) && !beat && (gap_cnt == GAP_W'(TIMEOUT - 1));

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         gap_cnt <= '0;
      end else if ((state_q == RUN) && !beat && !wd_fire) begin
         gap_cnt <= gap_cnt + 1'b1;
      end else begin
         gap_cnt <= '0;
      end
   end
`else
   assign wd_fire = 1'b0;
`endif

   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (last_beat) begin
         state_d = DONE;
      end else if (beat) begin
         state_d = RUN;
      end else begin
         case (state_q)
            IDLE:    state_d = IDLE;
            RUN:     state_d = wd_fire ? IDLE : RUN;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // Position counters; every wrap value equals the reset value so the last beat of a
   // frame leaves the sequencer ready for beat 0 of the next one
   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         ch_cnt      <= '0;
         col_cnt     <= '0;
         row_cnt     <= '0;
         col_end_ph  <= PH_K1;
         row_end_ph  <= PH_K1;
         col_st_ph   <= '0;
         row_st_ph   <= '0;
         out_col_cnt <= '0;
         out_row_cnt <= '0;
      end else if (wd_fire) begin
         ch_cnt      <= '0;
         col_cnt     <= '0;
         row_cnt     <= '0;
         col_end_ph  <= PH_K1;
         row_end_ph  <= PH_K1;
         col_st_ph   <= '0;
         row_st_ph   <= '0;
         out_col_cnt <= '0;
         out_row_cnt <= '0;
      end else if (beat) begin
         ch_cnt <= ch_wrap ? '0 : ch_cnt + 1'b1;
         if (col_adv) begin
            if (col_wrap) begin
               col_cnt     <= '0;
               col_end_ph  <= PH_K1;
               col_st_ph   <= '0;
               out_col_cnt <= '0;
            end else begin
               col_cnt     <= col_cnt + 1'b1;
               col_end_ph  <= col_hit ? PH_S1 : col_end_ph - 1'b1;
               col_st_ph   <= (col_st_ph == PH_S1) ? '0 : col_st_ph + 1'b1;
               out_col_cnt <= out_col_cnt + COL_W'(col_hit);
            end
         end
         if (row_adv) begin
            if (row_wrap) begin
               row_cnt     <= '0;
               row_end_ph  <= PH_K1;
               row_st_ph   <= '0;
               out_row_cnt <= '0;
            end else begin
               row_cnt     <= row_cnt + 1'b1;
               row_end_ph  <= row_hit ? PH_S1 : row_end_ph - 1'b1;
               row_st_ph   <= (row_st_ph == PH_S1) ? '0 : row_st_ph + 1'b1;
               out_row_cnt <= out_row_cnt + ROW_W'(row_hit);
            end
         end
      end
   end

   // Registered strobes; coordinates only update on a completing beat and hold otherwise
   always_ff @(posedge S_AXIS_ACLK or negedge S_AXIS_ARESETN) begin
      if (!S_AXIS_ARESETN) begin
         Cal_Valid  <= 1'b0;
         Frame_Done <= 1'b0;
         Err        <= 1'b0;
         Out_Row    <= '0;
         Out_Col    <= '0;
         Out_Ch     <= '0;
      end else begin
         Cal_Valid  <= win_hit;
         Frame_Done <= last_beat;
         Err        <= wd_fire;
         if (win_hit) begin
            Out_Row <= out_row_cnt;
            Out_Col <= out_col_cnt;
            Out_Ch  <= ch_cnt;
         end
      end
   end

endmodule
